// File: rtl/sdram_test_pkg.sv
// rtl/sdram_test_pkg.sv - shared types, LFSR taps and data-pattern function for the SDRAM soak tester
package sdram_test_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_NADDR = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Galois taps (right-shifting form) giving maximal-length sequences for common widths
  function automatic logic [63:0] lfsr_taps(input int data_w);
    case (data_w)
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] cur, input int data_w);
    logic [63:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ lfsr_taps(data_w);
    return nxt;
  endfunction

  // Address patterns replicate the address zero-extended to whole bytes, so byte lanes stay distinguishable
  function automatic logic [63:0] pattern(input mode_t mode, input logic [63:0] addr,
                                          input logic [63:0] lfsr, input logic pol,
                                          input int addr_w, input int data_w);
    logic [63:0] d;
    int          field_w;
    field_w = ((addr_w + 7) / 8) * 8;
    d = '0;
    case (mode)
      MODE_ADDR, MODE_NADDR: for (int i = 0; i < 64; i++) d[i] = addr[i % field_w];
      MODE_LFSR:             d = lfsr;
      default:               d = 64'd1 << (addr % 64'(data_w));
    endcase
    if (mode == MODE_NADDR) d = ~d;
    if (pol) d = ~d;
    return d;
  endfunction

endpackage

// File: rtl/sdram_test_patgen.sv
// rtl/sdram_test_patgen.sv - data word generator shared by write data and read expectation
module sdram_test_patgen
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              pol,
  input  logic [DATA_W-1:0] lfsr,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] lfsr_next
);

  assign data      = DATA_W'(pattern(mode_t'(mode), 64'(addr), 64'(lfsr), pol, ADDR_W, DATA_W));
  assign lfsr_next = DATA_W'(lfsr_step(64'(lfsr), DATA_W));

endmodule

// File: rtl/sdram_pattern_tester.sv
// rtl/sdram_pattern_tester.sv - SDRAM write/read-back soak tester on the slot-based controller port
// SDRAM_TEST_ERRLOG_EN enables capture of the first mismatch on err_addr/err_exp/err_got.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int IDLE_SLOTS = 1,
  parameter int PASSES     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  slot,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_W/8-1:0]   mem_ds,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_dout,
  input  logic [DATA_W-1:0]     mem_din,
  output logic                  busy,
  output logic                  done,
  output logic                  reading,
  output logic                  fail,
  output logic [15:0]           err_count,
  output logic [7:0]            pass_count,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [DATA_W-1:0]     err_exp,
  output logic [DATA_W-1:0]     err_got
);

  localparam int GW = $clog2(IDLE_SLOTS + 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] lfsr, lfsr_nxt, seed_r, exp_r, pat;
  logic [1:0]        mode_r;
  logic [GW-1:0]     gap;
  logic              pol, pend, fin;
  logic              access, last_addr, more, mismatch, start_ok;

  assign busy      = (state == ST_WR) || (state == ST_RD);
  assign done      = (state == ST_DONE);
  assign reading   = (state == ST_RD);
  assign start_ok  = start && !busy;
  assign access    = slot && (gap == '0);
  assign last_addr = &addr;
  assign more      = (PASSES == 0) || (({24'd0, pass_count} + 32'd1) < 32'(PASSES));
  assign mismatch  = slot && pend && (mem_din != exp_r);

  sdram_test_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_patgen (
    .mode      (mode_r),
    .addr      (addr),
    .pol       (pol),
    .lfsr      (lfsr),
    .data      (pat),
    .lfsr_next (lfsr_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_n = ST_WR;
      ST_WR:            if (access && last_addr) state_n = ST_RD;
      ST_RD:            if (slot && fin) state_n = more ? ST_WR : ST_DONE;
      default:          state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_oe     <= 1'b0;
      mem_ds     <= '0;
      mem_addr   <= '0;
      mem_dout   <= '0;
      fail       <= 1'b0;
      err_count  <= '0;
      pass_count <= '0;
      addr       <= '0;
      lfsr       <= '0;
      seed_r     <= '0;
      exp_r      <= '0;
      mode_r     <= '0;
      gap        <= '0;
      pol        <= 1'b0;
      pend       <= 1'b0;
      fin        <= 1'b0;
    end else if (start_ok) begin
      mode_r     <= mode;
      seed_r     <= (seed == '0) ? DATA_W'(1) : seed;
      lfsr       <= (seed == '0) ? DATA_W'(1) : seed;
      addr       <= '0;
      gap        <= '0;
      pol        <= 1'b0;
      pend       <= 1'b0;
      fin        <= 1'b0;
      fail       <= 1'b0;
      err_count  <= '0;
      pass_count <= '0;
      mem_ds     <= '1;
    end else if (slot && busy) begin
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
      pend   <= 1'b0;
      if (mismatch) begin
        fail <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (gap != '0) begin
        gap <= gap - GW'(1);
      end else begin
        // access slot; the idle slots that follow give the read data time to return
        gap      <= GW'(IDLE_SLOTS);
        mem_addr <= addr;
        addr     <= addr + ADDR_W'(1);
        lfsr     <= lfsr_nxt;
        if (state == ST_WR) begin
          mem_we   <= 1'b1;
          mem_dout <= pat;
          if (last_addr) lfsr <= seed_r;
        end else begin
          mem_oe <= 1'b1;
          exp_r  <= pat;
          pend   <= 1'b1;
          if (last_addr) fin <= 1'b1;
        end
      end
      if (fin) begin
        fin        <= 1'b0;
        pass_count <= pass_count + 8'd1;
        addr       <= '0;
        lfsr       <= seed_r;
        pol        <= ~pol;
        if (!more) mem_ds <= '0;
      end
    end
  end

`ifdef SDRAM_TEST_ERRLOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (start_ok) begin
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (mismatch && !fail) begin
      // the read address is still on mem_addr during the idle slot where data is checked
      err_addr <= mem_addr;
      err_exp  <= exp_r;
      err_got  <= mem_din;
    end
  end
`else
  assign err_addr = '0;
  assign err_exp  = '0;
  assign err_got  = '0;
`endif

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb/tb_sdram_pattern_tester.sv - scoreboard bench for sdram_pattern_tester (optionally with SDRAM_TEST_ERRLOG_EN)
module tb_sdram_pattern_tester;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, slot = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] seed = 16'd0;
  logic        mem_we, mem_oe, busy, done, reading, fail;
  logic [1:0]  mem_ds;
  logic [3:0]  mem_addr, err_addr;
  logic [15:0] mem_dout, mem_din = 16'd0, err_exp, err_got, err_count;
  logic [7:0]  pass_count;

  logic        reset_b = 1'b1, start_b = 1'b0, slot_b = 1'b1;
  logic [1:0]  mode_b = 2'd0;
  logic [15:0] seed_b = 16'd0;
  logic        mem_we_b, mem_oe_b, busy_b, done_b, reading_b, fail_b;
  logic [1:0]  mem_ds_b, mem_addr_b, err_addr_b;
  logic [15:0] mem_dout_b, mem_din_b = 16'd0, err_exp_b, err_got_b, err_count_b;
  logic [7:0]  pass_count_b;

  int n_checks = 0, n_fail = 0, phase = 0;
  logic [21:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [15:0] mem[16];
  logic [15:0] mem_b[4];
  logic        corrupt_en = 1'b0;
  logic [3:0]  corrupt_addr = 4'd5;

  sdram_pattern_tester #(.ADDR_W(4), .DATA_W(16), .IDLE_SLOTS(1), .PASSES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed), .slot(slot),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_ds(mem_ds), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .busy(busy), .done(done), .reading(reading),
    .fail(fail), .err_count(err_count), .pass_count(pass_count),
    .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got)
  );

  sdram_pattern_tester #(.ADDR_W(2), .DATA_W(16), .IDLE_SLOTS(1), .PASSES(0)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .mode(mode_b), .seed(seed_b), .slot(slot_b),
    .mem_we(mem_we_b), .mem_oe(mem_oe_b), .mem_ds(mem_ds_b), .mem_addr(mem_addr_b),
    .mem_dout(mem_dout_b), .mem_din(mem_din_b), .busy(busy_b), .done(done_b), .reading(reading_b),
    .fail(fail_b), .err_count(err_count_b), .pass_count(pass_count_b),
    .err_addr(err_addr_b), .err_exp(err_exp_b), .err_got(err_got_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    phase = (phase == 7) ? 0 : phase + 1;
    slot  = (phase == 0);
  end

  function automatic logic [15:0] lfsr16(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [15:0] exp_pat(input logic [1:0] m, input logic [3:0] a,
                                          input logic p, input logic [15:0] l);
    logic [15:0] d;
    case (m)
      2'd0:    d = {4'h0, a, 4'h0, a};
      2'd1:    d = ~{4'h0, a, 4'h0, a};
      2'd2:    d = l;
      default: d = 16'h0001 << a;
    endcase
    return p ? ~d : d;
  endfunction

  function automatic void push_expect(input logic [1:0] m, input logic [15:0] sd);
    logic [15:0] l;
    for (int p = 0; p < 2; p++) begin
      l = (sd == 16'd0) ? 16'd1 : sd;
      for (int a = 0; a < 16; a++) begin
        wr_q.push_back({4'(a), exp_pat(m, 4'(a), p[0], l), 2'b11});
        rd_q.push_back(4'(a));
        l = lfsr16(l);
      end
    end
  endfunction

  // ideal memory plus scoreboard for the main instance
  always begin
    logic        s;
    logic [21:0] e;
    logic [3:0]  ea;
    @(posedge clk);
    s = slot;
    #1;
    if (s && mem_we) begin
      mem[mem_addr] = mem_dout;
      n_checks++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %0d data %h, required no write", mem_addr, mem_dout);
      end else begin
        e = wr_q.pop_front();
        if ({mem_addr, mem_dout, mem_ds} !== e) begin
          n_fail++;
          $display("FAIL wr_beat: got addr %0d data %h ds %b, required addr %0d data %h ds %b",
                   mem_addr, mem_dout, mem_ds, e[21:18], e[17:2], e[1:0]);
        end
      end
    end
    if (s && mem_oe) begin
      mem_din = mem[mem_addr] ^ ((corrupt_en && mem_addr == corrupt_addr) ? 16'h0008 : 16'h0000);
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got addr %0d, required no read", mem_addr);
      end else begin
        ea = rd_q.pop_front();
        if (mem_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_addr: got %0d, required %0d", mem_addr, ea);
        end
      end
    end
  end

  // memory for the wrap instance returns the inverse of every stored word
  always begin
    @(posedge clk);
    #1;
    if (mem_we_b) mem_b[mem_addr_b] = mem_dout_b;
    if (mem_oe_b) mem_din_b = ~mem_b[mem_addr_b];
  end

  task automatic do_start(input logic [1:0] m, input logic [15:0] sd, input bit coincide);
    int guard;
    guard = 0;
    do begin
      @(negedge clk); #1;
      guard++;
    end while (slot !== coincide && guard < 20);
    push_expect(m, sd);
    mode  = m;
    seed  = sd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: got done %b, required 1", done); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({mem_we, mem_oe, mem_ds, mem_addr, mem_dout} !== 24'd0) begin
      n_fail++; $display("FAIL reset_mem: got %h, required 0", {mem_we, mem_oe, mem_ds, mem_addr, mem_dout});
    end
    n_checks++;
    if ({busy, done, reading, fail} !== 4'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000", {busy, done, reading, fail});
    end
    n_checks++;
    if ({err_count, pass_count} !== 24'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h, required 0", {err_count, pass_count});
    end
    n_checks++;
    if ({err_addr, err_exp, err_got} !== 36'd0) begin
      n_fail++; $display("FAIL reset_errlog: got %h, required 0", {err_addr, err_exp, err_got});
    end
    reset   = 1'b0;
    reset_b = 1'b0;
  endtask

  task automatic test_mode0;
    do_start(2'd0, 16'h1234, 1'b0);
    n_checks++;
    if ({busy, done, reading} !== 3'b100) begin
      n_fail++; $display("FAIL mode0_busy: got %b, required 100", {busy, done, reading});
    end
    wait_done(2000);
    n_checks++;
    if ({busy, fail, err_count, pass_count} !== {1'b0, 1'b0, 16'd0, 8'd2}) begin
      n_fail++; $display("FAIL mode0_end: got busy %b fail %b err %0d passes %0d, required 0 0 0 2",
                         busy, fail, err_count, pass_count);
    end
    n_checks++;
    if (wr_q.size() + rd_q.size() != 0) begin
      n_fail++; $display("FAIL mode0_left: got %0d beats outstanding, required 0", wr_q.size() + rd_q.size());
    end
  endtask

  task automatic test_patterns;
    logic [1:0]  tm[4];
    logic [15:0] ts[4];
    tm = '{2'd1, 2'd2, 2'd2, 2'd3};
    ts = '{16'h0000, 16'hACE1, 16'h0000, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      do_start(tm[k], ts[k], 1'b0);
      wait_done(2000);
      n_checks++;
      if ({fail, err_count, pass_count} !== {1'b0, 16'd0, 8'd2} || wr_q.size() + rd_q.size() != 0) begin
        n_fail++; $display("FAIL pattern_mode%0d_seed%h: got fail %b err %0d passes %0d left %0d, required 0 0 2 0",
                           tm[k], ts[k], fail, err_count, pass_count, wr_q.size() + rd_q.size());
      end
    end
  endtask

  task automatic test_corrupt;
    corrupt_en = 1'b1;
    do_start(2'd0, 16'h0000, 1'b0);
    wait_done(2000);
    corrupt_en = 1'b0;
    n_checks++;
    if ({fail, err_count, pass_count} !== {1'b1, 16'd2, 8'd2}) begin
      n_fail++; $display("FAIL corrupt_counts: got fail %b err %0d passes %0d, required 1 2 2", fail, err_count, pass_count);
    end
`ifdef SDRAM_TEST_ERRLOG_EN
    n_checks++;
    if ({err_addr, err_exp, err_got} !== {4'd5, 16'h0505, 16'h050D}) begin
      n_fail++; $display("FAIL errlog: got addr %0d exp %h got %h, required 5 0505 050d", err_addr, err_exp, err_got);
    end
    n_checks++;
    if (err_got !== (err_exp ^ 16'h0008)) begin
      n_fail++; $display("FAIL errlog_bit3: got %h, required %h", err_got, err_exp ^ 16'h0008);
    end
`else
    n_checks++;
    if ({err_addr, err_exp, err_got} !== 36'd0) begin
      n_fail++; $display("FAIL errlog_tied: got %h, required 0", {err_addr, err_exp, err_got});
    end
`endif
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    do_start(2'd0, 16'h0000, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (reading && mem_oe && mem_addr == 4'd9) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL reset_mid_reach: got no read of addr 9, required one"); end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_we, mem_oe, mem_ds, mem_addr, mem_dout, busy, done, reading, fail, err_count, pass_count} !== 52'd0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h, required 0",
                         {mem_we, mem_oe, mem_ds, mem_addr, mem_dout, busy, done, reading, fail, err_count, pass_count});
    end
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_start_slot;
    logic s;
    bit   seen;
    do_start(2'd0, 16'h0000, 1'b1);
    n_checks++;
    if ({mem_we, busy} !== 2'b01) begin
      n_fail++; $display("FAIL start_slot_edge: got we %b busy %b, required 0 1", mem_we, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); s = slot; #1;
      if (s) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || {mem_we, mem_addr} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL start_slot_first: got we %b addr %0d, required 1 0", mem_we, mem_addr);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mem_we && mem_addr == 4'd4) break;
    end
    mode  = 2'd3;
    seed  = 16'h0005;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 2'd0;
    wait_done(2000);
    n_checks++;
    if ({fail, pass_count} !== {1'b0, 8'd2} || wr_q.size() + rd_q.size() != 0) begin
      n_fail++; $display("FAIL busy_start_ignored: got fail %b passes %0d left %0d, required 0 2 0",
                         fail, pass_count, wr_q.size() + rd_q.size());
    end
  endtask

  task automatic test_wrap;
    bit seen255, wrapped;
    seen255 = 1'b0;
    wrapped = 1'b0;
    @(negedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if (pass_count_b == 8'd255) seen255 = 1'b1;
      if (seen255 && pass_count_b == 8'd0) begin wrapped = 1'b1; break; end
    end
    n_checks++;
    if (!wrapped) begin n_fail++; $display("FAIL wrap_reach: got passes %0d, required wrap 255->0", pass_count_b); end
    n_checks++;
    if ({err_count_b, fail_b, busy_b} !== {16'd1024, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL wrap_errors: got err %0d fail %b busy %b, required 1024 1 1", err_count_b, fail_b, busy_b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no summary by 2 ms, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode0();
    test_patterns();
    test_corrupt();
    test_reset_mid();
    test_start_slot();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
